// File: rtl/rca_nibble_sequencer_if.sv
// Operand/result handshake bundle for rca_nibble_sequencer.
//
// Operand side : in_valid / in_ready, in_a, in_b, in_cin
// Result side  : out_valid / out_ready, out_sum, out_cout, out_ovf
//
// master : the surrounding system (drives operands, accepts results)
// slave  : the sequencer (accepts operands, presents results)
interface rca_nibble_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf
    );
endinterface

// File: rtl/rca_nibble_sequencer.sv
// Nibble-serial add controller around one external 4-bit ripple-carry adder slice.
//
// A WIDTH-bit add is performed as NIB = WIDTH/4 passes through the shared slice,
// least-significant nibble first. The inter-nibble carry is kept in a register and
// the slice results are shifted into a sum register from the top, so after the last
// pass the register holds the full sum in the right bit order.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          operand/result handshakes (slave side of rca_nibble_sequencer_if)
//   slice_a_o    nibble of A for the slice (0 outside RUN)
//   slice_b_o    nibble of B for the slice (0 outside RUN)
//   slice_cin_o  carry into the slice (0 outside RUN)
//   slice_sum_i  combinational slice sum
//   slice_cout_i combinational slice carry out
//   busy_o       high while an add is in RUN or waiting in DONE
//
// The bus interface instance must be built with the same WIDTH as this module.
module rca_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    rca_nibble_sequencer_if.slave        bus,
    output logic [3:0]                   slice_a_o,
    output logic [3:0]                   slice_b_o,
    output logic                         slice_cin_o,
    input  logic [3:0]                   slice_sum_i,
    input  logic                         slice_cout_i,
    output logic                         busy_o
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("rca_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic             run;
    logic             last;
    logic [WIDTH-1:0] sum_shift;

    assign accept = (state_q == StIdle) && bus.in_valid;
    assign run    = (state_q == StRun);
    assign last   = run && (cnt_q == CntLast);

    // New slice nibble enters at the top; after NIB passes the first nibble has
    // been pushed down to bits [3:0]. Written as a shift of the concatenation so
    // the WIDTH == 4 case (nothing kept from sum_q) needs no special handling.
    assign sum_shift = WIDTH'({slice_sum_i, sum_q} >> 4);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy_o        = 1'b0;
        slice_a_o     = 4'h0;
        slice_b_o     = 4'h0;
        slice_cin_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
            end
            StRun: begin
                busy_o      = 1'b1;
                slice_a_o   = a_q[3:0];
                slice_b_o   = b_q[3:0];
                slice_cin_o = carry_q;
            end
            StDone: begin
                busy_o        = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;

        if (accept) begin
            // Operands are captured so the source may change them right away.
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            carry_d = bus.in_cin;
            a_msb_d = bus.in_a[WIDTH-1];
            b_msb_d = bus.in_b[WIDTH-1];
            cnt_d   = '0;
            sum_d   = '0;
        end else if (run) begin
            sum_d   = sum_shift;
            carry_d = slice_cout_i;
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            cnt_d   = cnt_q + CntW'(1);
            if (last) begin
                // The final pass handles the sign nibble, so overflow comes from
                // the operand signs and the sum's top bit straight off the slice.
                out_sum_d  = sum_shift;
                out_cout_d = slice_cout_i;
                out_ovf_d  = (a_msb_q == b_msb_q) && (slice_sum_i[3] != a_msb_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            cnt_q      <= cnt_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign bus.out_sum  = out_sum_q;
    assign bus.out_cout = out_cout_q;
    assign bus.out_ovf  = out_ovf_q;

endmodule
